jt7759_cmdq: RTL and testbench

Command queue and start sequencer for a jt7759 running in slave mode (mdn=0). It buffers sample numbers written by the host CPU in a small FIFO. It then issues each one to the jt7759 CPU interface (cs/wrn/din) only when the chip reports idle (busyn=1) and ready (drqn=1). This lets game CPUs fire sound requests back-to-back without polling busy. It sits between the CPU bus decoder and jt7759 and uses the same cen_ctl enable.

---
 rtl/jt7759_cmdq.sv | 247 ++++++++++++++++++++++++
 tb/tb_jt7759_cmdq.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt7759_cmdq.sv
// -----------------------------------------------------------------------------
// jt7759_cmdq
//
// Command queue and start sequencer for a jt7759 in slave mode (mdn=0).
// The host CPU pushes sample numbers into a small circular FIFO. Each entry is
// written to the jt7759 CPU interface (cs/wrn/din) only once the chip reports
// idle (busyn=1) and ready (drqn=1). The game CPU can therefore fire sound
// requests back-to-back without polling busy. All sequencing advances on the
// shared cen_ctl enable.
//
// Optional feature macro: JT7759_CMDQ_TIMEOUT_EN
//   defined     : ACK phase gives up after 2^TOW-1 cen_ctl ticks without busyn
//                 falling, sets the sticky err flag and drops the entry.
//   not defined : ACK waits for busyn==0 indefinitely; err is tied low.
//
// Parameters:
//   QW   log2 of FIFO depth
//   WRW  write strobe width in cen_ctl ticks (1..7)
//   TOW  ACK timeout counter width
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active high
//   cen_ctl    control clock enable (shared with jt7759)
//   cpu_we     push request, one clk per sample
//   cpu_din    sample number to push
//   cpu_flush  discard all queued entries
//   cpu_full   FIFO full
//   q_cnt      entries held
//   ovf        sticky: a push was dropped because the FIFO was full
//   err        sticky: ACK timeout
//   busyn      from jt7759, 1 = idle
//   drqn       from jt7759, 1 = ready for a command
//   snd_cs     to jt7759 cs
//   snd_wrn    to jt7759 wrn, active low
//   snd_din    to jt7759 din
//   active     high whenever the sequencer is outside IDLE
// -----------------------------------------------------------------------------
module jt7759_cmdq #(
  parameter int QW  = 2,
  parameter int WRW = 2,
  parameter int TOW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen_ctl,
  input  logic          cpu_we,
  input  logic [7:0]    cpu_din,
  input  logic          cpu_flush,
  output logic          cpu_full,
  output logic [QW:0]   q_cnt,
  output logic          ovf,
  output logic          err,
  input  logic          busyn,
  input  logic          drqn,
  output logic          snd_cs,
  output logic          snd_wrn,
  output logic [7:0]    snd_din,
  output logic          active
);

  localparam int            DEPTH   = 1 << QW;
  localparam logic [QW:0]   DEPTH_L = (QW+1)'(DEPTH);
  localparam logic [2:0]    WRW_L   = 3'(WRW);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    ACK,
    PLAY
  } state_t;

  state_t         state, state_nxt;

  logic [7:0]     mem [DEPTH];
  logic [QW-1:0]  rd_ptr, wr_ptr;
  logic [QW:0]    cnt_nxt;

  logic [2:0]     stb_cnt, stb_cnt_nxt;
  logic           snd_cs_nxt, snd_wrn_nxt;
  logic [7:0]     snd_din_nxt;

  logic           issue;     // IDLE -> ISSUE this cycle
  logic           pop;       // strobe ends this cycle
  logic           pop_eff;   // strobe end that really removes a FIFO entry
  logic           push_ok;
  // The entry being strobed is still in the FIFO. A flush during ISSUE has
  // already discarded it, so the end of that strobe must not pop whatever was
  // pushed after the flush.
  logic           head_live;

`ifdef JT7759_CMDQ_TIMEOUT_EN
  logic [TOW-1:0] to_cnt, to_cnt_nxt;
  logic           err_set;
`endif

  // ---------------------------------------------------------------------------
  // Sequencer next-state and registered-output next values
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nxt   = state;
    snd_cs_nxt  = snd_cs;
    snd_wrn_nxt = snd_wrn;
    snd_din_nxt = snd_din;
    stb_cnt_nxt = stb_cnt;
    issue       = 1'b0;
    pop         = 1'b0;
`ifdef JT7759_CMDQ_TIMEOUT_EN
    to_cnt_nxt  = to_cnt;
    err_set     = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (cen_ctl && (q_cnt != '0) && busyn && drqn) begin
          snd_din_nxt = mem[rd_ptr];
          snd_cs_nxt  = 1'b1;
          snd_wrn_nxt = 1'b0;
          stb_cnt_nxt = WRW_L;
          issue       = 1'b1;
          state_nxt   = ISSUE;
        end
      end

      // The strobe runs to completion even if busyn/drqn move meanwhile.
      ISSUE: begin
        if (cen_ctl) begin
          if (stb_cnt == 3'd1) begin
            snd_wrn_nxt = 1'b1;
            snd_cs_nxt  = 1'b0;
            pop         = 1'b1;
`ifdef JT7759_CMDQ_TIMEOUT_EN
            to_cnt_nxt  = '0;
`endif
            state_nxt   = ACK;
          end else begin
            stb_cnt_nxt = stb_cnt - 1'b1;
          end
        end
      end

      ACK: begin
        if (!busyn) begin
          state_nxt = PLAY;
`ifdef JT7759_CMDQ_TIMEOUT_EN
        end else if (cen_ctl) begin
          to_cnt_nxt = to_cnt + 1'b1;
          // The entry is treated as consumed; it is not retried.
          if (&to_cnt_nxt) begin
            err_set   = 1'b1;
            state_nxt = IDLE;
          end
`endif
        end
      end

      PLAY: begin
        if (busyn) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping
  // ---------------------------------------------------------------------------
  assign pop_eff = pop && head_live;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is taken.
  assign push_ok = cpu_we && ((q_cnt != DEPTH_L) || pop_eff);

  always_comb begin
    cnt_nxt = q_cnt;
    if (cpu_flush)               cnt_nxt = '0;
    else if (push_ok && !pop_eff) cnt_nxt = q_cnt + 1'b1;
    else if (!push_ok && pop_eff) cnt_nxt = q_cnt - 1'b1;
  end

  // NOTE: the storage array has no reset; validity is tracked solely by the
  // pointers and q_cnt, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push_ok && !cpu_flush) mem[wr_ptr] <= cpu_din;
  end

  // ---------------------------------------------------------------------------
  // State, pointers, flags and registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      q_cnt     <= '0;
      cpu_full  <= 1'b0;
      ovf       <= 1'b0;
      snd_cs    <= 1'b0;
      snd_wrn   <= 1'b1;
      snd_din   <= 8'h00;
      stb_cnt   <= '0;
      active    <= 1'b0;
      head_live <= 1'b0;
    end else begin
      state    <= state_nxt;
      snd_cs   <= snd_cs_nxt;
      snd_wrn  <= snd_wrn_nxt;
      snd_din  <= snd_din_nxt;
      stb_cnt  <= stb_cnt_nxt;
      active   <= (state_nxt != IDLE);
      q_cnt    <= cnt_nxt;
      cpu_full <= (cnt_nxt == DEPTH_L);

      if (cpu_flush) begin
        // Flush wins over a simultaneous push; the in-flight strobe continues.
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        ovf       <= 1'b0;
        head_live <= 1'b0;
      end else begin
        if (push_ok)           wr_ptr <= wr_ptr + 1'b1;
        if (pop_eff)           rd_ptr <= rd_ptr + 1'b1;
        if (cpu_we && !push_ok) ovf   <= 1'b1;
        if (issue)             head_live <= 1'b1;
        else if (pop)          head_live <= 1'b0;
      end
    end
  end

`ifdef JT7759_CMDQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      to_cnt <= to_cnt_nxt;
      if (cpu_flush)    err <= 1'b0;
      else if (err_set) err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_jt7759_cmdq.sv
// -----------------------------------------------------------------------------
// tb_jt7759_cmdq
//
// Self-checking bench for jt7759_cmdq. Stimulus pushes sample numbers and
// queues the value expected on snd_din; a monitor pops that queue at the end
// of every write strobe and compares data and strobe width. A small jt7759
// model drops busyn shortly after each strobe and raises it again later, or
// the busyn level is held manually.
// Inputs are driven and status is sampled on the falling clock edge; the
// strobe monitor samples 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_jt7759_cmdq;

  localparam int QW      = 2;
  localparam int WRW     = 2;
  localparam int TOW     = 4;
  localparam int CEN_DIV = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cen_ctl;
  logic          cpu_we;
  logic [7:0]    cpu_din;
  logic          cpu_flush;
  logic          cpu_full;
  logic [QW:0]   q_cnt;
  logic          ovf;
  logic          err;
  logic          busyn;
  logic          drqn;
  logic          snd_cs;
  logic          snd_wrn;
  logic [7:0]    snd_din;
  logic          active;

  int            errors = 0;
  int            checks = 0;
  logic [7:0]    exp_q [$];
  int            strobe_cnt = 0;

  // jt7759 model controls
  bit            model_en  = 1'b1;
  logic          man_busyn = 1'b1;

  jt7759_cmdq #(.QW(QW), .WRW(WRW), .TOW(TOW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cen_ctl   (cen_ctl),
    .cpu_we    (cpu_we),
    .cpu_din   (cpu_din),
    .cpu_flush (cpu_flush),
    .cpu_full  (cpu_full),
    .q_cnt     (q_cnt),
    .ovf       (ovf),
    .err       (err),
    .busyn     (busyn),
    .drqn      (drqn),
    .snd_cs    (snd_cs),
    .snd_wrn   (snd_wrn),
    .snd_din   (snd_din),
    .active    (active)
  );

  always #5 clk = ~clk;

  // cen_ctl: one clk high out of every CEN_DIV
  initial begin
    int div;
    div     = 0;
    cen_ctl = 1'b0;
    forever begin
      @(negedge clk);
      div     = (div + 1) % CEN_DIV;
      cen_ctl = (div == 0);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // jt7759 model: busyn drops 2 clks after a strobe ends, rises 20 clks later.
  initial begin
    int   m_t;
    logic prev_wrn;
    m_t      = 0;
    prev_wrn = 1'b1;
    busyn    = 1'b1;
    forever begin
      @(negedge clk);
      if (!model_en) begin
        busyn = man_busyn;
        m_t   = 0;
      end else if (m_t > 0) begin
        m_t++;
        if (m_t == 3) busyn = 1'b0;
        if (m_t == 23) begin
          busyn = 1'b1;
          m_t   = 0;
        end
      end else begin
        busyn = 1'b1;
        if (prev_wrn === 1'b0 && snd_wrn === 1'b1) m_t = 1;
      end
      prev_wrn = snd_wrn;
    end
  end

  // Strobe monitor / scoreboard
  initial begin
    bit         in_strobe;
    int         low_cnt;
    logic [7:0] exp_v;
    in_strobe = 1'b0;
    low_cnt   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        in_strobe = 1'b0;  // strobe aborted by reset, nothing issued
      end else if (snd_wrn === 1'b0) begin
        if (!in_strobe) begin
          in_strobe = 1'b1;
          low_cnt   = 0;
          check("strobe_cs_high", int'(snd_cs), 1);
          check("strobe_start_busyn", int'(busyn), 1);
        end
        low_cnt++;
      end else if (in_strobe) begin
        in_strobe = 1'b0;
        strobe_cnt++;
        check("strobe_width_clks", low_cnt, WRW * CEN_DIV);
        check("strobe_cs_released", int'(snd_cs), 0);
        check("strobe_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_v = exp_q.pop_front();
          check("strobe_din", int'(snd_din), int'(exp_v));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic push(input logic [7:0] v, input bit expect_issue);
    @(negedge clk);
    cpu_we  = 1'b1;
    cpu_din = v;
    if (expect_issue) exp_q.push_back(v);
    @(negedge clk);
    cpu_we  = 1'b0;
  endtask

  task automatic push_flush(input logic [7:0] v);
    @(negedge clk);
    cpu_we    = 1'b1;
    cpu_din   = v;
    cpu_flush = 1'b1;
    @(negedge clk);
    cpu_we    = 1'b0;
    cpu_flush = 1'b0;
  endtask

  task automatic set_manual(input logic b);
    model_en  = 1'b0;
    man_busyn = b;
    repeat (2) @(negedge clk);
  endtask

  task automatic set_auto();
    model_en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (q_cnt == '0 && !active && exp_q.size() == 0) break;
      @(negedge clk);
    end
    check(name, int'(q_cnt == '0 && !active && exp_q.size() == 0), 1);
  endtask

  task automatic wait_strobes(input string name, input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (strobe_cnt >= target) break;
      @(negedge clk);
    end
    check(name, strobe_cnt, target);
  endtask

  initial begin
    int base;
    rst       = 1'b1;
    cpu_we    = 1'b0;
    cpu_din   = 8'h00;
    cpu_flush = 1'b0;
    drqn      = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_snd_cs", int'(snd_cs), 0);
    check("rst_snd_wrn", int'(snd_wrn), 1);
    check("rst_snd_din", int'(snd_din), 0);
    check("rst_cpu_full", int'(cpu_full), 0);
    check("rst_q_cnt", int'(q_cnt), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_err", int'(err), 0);
    check("rst_active", int'(active), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: single push with idle chip
    push(8'h05, 1'b1);
    check("t1_q_cnt_after_push", int'(q_cnt), 1);
    wait_strobes("t1_strobe_seen", 1, 200);
    check("t1_q_cnt_after_pop", int'(q_cnt), 0);
    check("t1_active_after_strobe", int'(active), 1);
    wait_idle("t1_back_to_idle", 300);

    // 2: three pushes while busy, then release
    set_manual(1'b0);
    base = strobe_cnt;
    push(8'h03, 1'b1);
    push(8'h07, 1'b1);
    push(8'h0A, 1'b1);
    repeat (20) @(negedge clk);
    check("t2_q_cnt", int'(q_cnt), 3);
    check("t2_no_strobe_while_busy", strobe_cnt, base);
    check("t2_idle_while_busy", int'(active), 0);
    set_auto();
    wait_strobes("t2_three_strobes", base + 3, 1000);
    wait_idle("t2_drained", 300);

    // 3: overflow, fifth push dropped
    set_manual(1'b0);
    push(8'h11, 1'b1);
    push(8'h22, 1'b1);
    push(8'h33, 1'b1);
    push(8'h44, 1'b1);
    check("t3_full_at_4", int'(cpu_full), 1);
    check("t3_no_ovf_yet", int'(ovf), 0);
    push(8'h55, 1'b0);
    check("t3_q_cnt_capped", int'(q_cnt), 4);
    check("t3_ovf_set", int'(ovf), 1);
    check("t3_still_full", int'(cpu_full), 1);
    set_auto();
    wait_idle("t3_drained", 2000);
    check("t3_ovf_sticky", int'(ovf), 1);

    // 4: push + flush same cycle with two entries queued
    set_manual(1'b0);
    push(8'h01, 1'b0);
    push(8'h02, 1'b0);
    check("t4_q_cnt_before_flush", int'(q_cnt), 2);
    push_flush(8'h03);
    check("t4_q_cnt_flushed", int'(q_cnt), 0);
    check("t4_ovf_cleared", int'(ovf), 0);
    check("t4_full_cleared", int'(cpu_full), 0);
    base = strobe_cnt;
    set_auto();
    repeat (200) @(negedge clk);
    check("t4_no_strobe_after_flush", strobe_cnt, base);
    check("t4_idle", int'(active), 0);

    // 5: chip never acknowledges
    set_manual(1'b1);
    base = strobe_cnt;
    push(8'h21, 1'b1);
    push(8'h22, 1'b1);
    wait_strobes("t5_first_strobe", base + 1, 200);
    check("t5_err_clear_in_ack", int'(err), 0);
`ifdef JT7759_CMDQ_TIMEOUT_EN
    wait_strobes("t5_second_after_timeout", base + 2, 500);
    wait_idle("t5_idle_after_timeouts", 500);
    check("t5_err_set", int'(err), 1);
`else
    repeat (200) @(negedge clk);
    check("t5_stuck_in_ack", int'(active), 1);
    check("t5_err_tied_low", int'(err), 0);
    check("t5_second_waiting", int'(q_cnt), 1);
    check("t5_no_second_strobe", strobe_cnt, base + 1);
    set_manual(1'b0);
    repeat (4) @(negedge clk);
    set_auto();
    wait_strobes("t5_second_after_play", base + 2, 500);
    wait_idle("t5_idle", 500);
`endif

    // 6: reset in the middle of ISSUE
    set_auto();
    push(8'h40, 1'b0);
    push(8'h41, 1'b0);
    for (int i = 0; i < 200; i++) begin
      if (snd_wrn === 1'b0) break;
      @(negedge clk);
    end
    check("t6_in_issue", int'(snd_wrn), 0);
    rst = 1'b1;
    @(negedge clk);
    check("t6_wrn_released", int'(snd_wrn), 1);
    check("t6_cs_released", int'(snd_cs), 0);
    check("t6_q_cnt_emptied", int'(q_cnt), 0);
    check("t6_active_low", int'(active), 0);
    check("t6_err_cleared", int'(err), 0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("t6_stays_idle", int'(active), 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
